// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matmul result egress path.
package matmul_pkg;

  localparam int ACC_W_DEF = 32;
  localparam int OUT_W_DEF = 32;
  // Working width for saturation math; accumulators up to 64 bits are supported.
  localparam int SAT_W = 64;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_e;

  typedef struct packed {
    logic signed [SAT_W-1:0] data;
    logic                    sat;
  } sat_res_t;

  function automatic sat_res_t sat_narrow(input logic signed [SAT_W-1:0] value,
                                          input int out_w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_res_t res;
    res.data = value;
    res.sat  = 1'b0;
    if (out_w < SAT_W) begin
      hi = (SAT_W'(1) << (out_w - 1)) - SAT_W'(1);
      lo = ~hi;
      if (value > hi) begin
        res.data = hi;
        res.sat  = 1'b1;
      end else if (value < lo) begin
        res.data = lo;
        res.sat  = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/matmul_result_streamer_acc_saturate.sv
// Combinational signed narrowing of one accumulator word to the stream width.
module acc_saturate
  import matmul_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] data,
  output logic                    sat
);

  if (OUT_W == ACC_W) begin : g_pass
    assign data = acc;
    assign sat  = 1'b0;
  end else begin : g_narrow
    sat_res_t res;
    logic     unused_hi;
    assign res       = sat_narrow(SAT_W'(acc), OUT_W);
    assign data      = res.data[OUT_W-1:0];
    assign sat       = res.sat;
    // Clamped value always fits in OUT_W bits; upper bits are pure sign copies.
    assign unused_hi = ^res.data[SAT_W-1:OUT_W];
  end

endmodule

// File: rtl/matmul_result_streamer.sv
// Snapshots the M x N accumulator matrix and streams it row-major over AXI4-Stream.
// state  | meaning
// IDLE   | no snapshot held, waiting for start
// STREAM | snapshot held, presenting element idx with tvalid high
module matmul_result_streamer
  import matmul_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int M     = 2,
  parameter int N     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [ACC_W-1:0] C [M][N],
  output logic                    busy,
  output logic                    done,
  output logic signed [OUT_W-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser
);

  localparam int NUM   = M * N;
  localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

  stream_state_e           state_q, state_d;
  logic [IDX_W-1:0]        idx, idx_next;
  logic signed [ACC_W-1:0] c_flat [NUM];
  logic signed [ACC_W-1:0] snap   [NUM];
  logic signed [ACC_W-1:0] sel_elem;
  logic signed [OUT_W-1:0] sat_data;
  logic                    sat_flag;
  logic                    capture, advance, finish;

  always_comb begin
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        c_flat[i*N + j] = C[i][j];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          capture = 1'b1;
        end
      end
      STREAM: begin
        if (m_axis_tvalid && m_axis_tready) begin
          if (idx == LAST_IDX) begin
            state_d = IDLE;
            finish  = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end
      end
    endcase
  end

  assign idx_next = (idx == LAST_IDX) ? '0 : idx + 1'b1;

  // Element 0 comes straight from C on capture so it is ready the very next cycle.
  assign sel_elem = capture ? c_flat[0] : snap[idx_next];

  acc_saturate #(
    .ACC_W(ACC_W),
    .OUT_W(OUT_W)
  ) u_sat (
    .acc (sel_elem),
    .data(sat_data),
    .sat (sat_flag)
  );

  always_ff @(posedge clk) begin
    if (capture) begin
      snap <= c_flat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      state_q <= state_d;
      done    <= finish;
      if (capture) begin
        idx           <= '0;
        busy          <= 1'b1;
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= sat_data;
        m_axis_tuser  <= sat_flag;
        m_axis_tlast  <= (LAST_IDX == '0);
      end else if (advance) begin
        idx           <= idx_next;
        m_axis_tdata  <= sat_data;
        m_axis_tuser  <= sat_flag;
        m_axis_tlast  <= (idx_next == LAST_IDX);
      end else if (finish) begin
        busy          <= 1'b0;
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_matmul_result_streamer.sv
// Directed bench: a full-width instance and a 16-bit saturating instance share control.
module tb_matmul_result_streamer;

  logic clk;
  logic rst;
  logic start;
  logic tready;
  logic signed [31:0] c_a [2][2];
  logic signed [31:0] c_b [2][2];

  logic        busy_a, done_a, tvalid_a, tlast_a, tuser_a;
  logic [31:0] tdata_a;
  logic        busy_b, done_b, tvalid_b, tlast_b, tuser_b;
  logic [15:0] tdata_b;

  int n_checks = 0;
  int n_pass   = 0;

  matmul_result_streamer #(.ACC_W(32), .OUT_W(32), .M(2), .N(2)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .C            (c_a),
    .busy         (busy_a),
    .done         (done_a),
    .m_axis_tdata (tdata_a),
    .m_axis_tvalid(tvalid_a),
    .m_axis_tready(tready),
    .m_axis_tlast (tlast_a),
    .m_axis_tuser (tuser_a)
  );

  matmul_result_streamer #(.ACC_W(32), .OUT_W(16), .M(2), .N(2)) u_sat (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .C            (c_b),
    .busy         (busy_b),
    .done         (done_b),
    .m_axis_tdata (tdata_b),
    .m_axis_tvalid(tvalid_b),
    .m_axis_tready(tready),
    .m_axis_tlast (tlast_b),
    .m_axis_tuser (tuser_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        tready;
    logic        valid;
    logic [31:0] data;
    logic        last;
    logic        busy;
    logic        done;
    logic [15:0] sdata;
    logic        suser;
    logic        chk_sat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic r, input logic v, input logic [31:0] d,
                              input logic l, input logic b, input logic dn,
                              input logic [15:0] sd, input logic su, input logic cs);
    vec_t t;
    t.start = s; t.tready = r; t.valid = v; t.data = d; t.last = l;
    t.busy = b; t.done = dn; t.sdata = sd; t.suser = su; t.chk_sat = cs;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input logic s, input logic r);
    start  = s;
    tready = r;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic set_ca(input logic signed [31:0] a, input logic signed [31:0] b,
                        input logic signed [31:0] c, input logic signed [31:0] d);
    c_a[0][0] = a; c_a[0][1] = b; c_a[1][0] = c; c_a[1][1] = d;
  endtask

  task automatic run_table(input string tag);
    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].start, vecs[k].tready);
      check($sformatf("%s[%0d] tvalid", tag, k), 64'(tvalid_a), 64'(vecs[k].valid));
      if (vecs[k].valid) begin
        check($sformatf("%s[%0d] tdata", tag, k), 64'(tdata_a), 64'(vecs[k].data));
        check($sformatf("%s[%0d] tlast", tag, k), 64'(tlast_a), 64'(vecs[k].last));
        check($sformatf("%s[%0d] tuser", tag, k), 64'(tuser_a), 64'd0);
      end
      check($sformatf("%s[%0d] busy", tag, k), 64'(busy_a), 64'(vecs[k].busy));
      check($sformatf("%s[%0d] done", tag, k), 64'(done_a), 64'(vecs[k].done));
      if (vecs[k].chk_sat) begin
        check($sformatf("%s[%0d] sat tdata", tag, k), 64'(tdata_b), 64'(vecs[k].sdata));
        check($sformatf("%s[%0d] sat tuser", tag, k), 64'(tuser_b), 64'(vecs[k].suser));
      end
    end
  endtask

  initial begin
    int done_cnt;
    int vld_cnt;
    rst = 1'b1; start = 1'b0; tready = 1'b1;
    set_ca(1, 2, 3, 4);
    c_b[0][0] = 32'sd70000; c_b[0][1] = -32'sd70000;
    c_b[1][0] = 32'sd32767; c_b[1][1] = -32'sd5;
    step(0, 1);
    step(0, 1);
    check("reset tvalid", 64'(tvalid_a), 64'd0);
    check("reset busy", 64'(busy_a), 64'd0);
    check("reset done", 64'(done_a), 64'd0);
    check("reset tlast", 64'(tlast_a), 64'd0);
    check("reset tuser", 64'(tuser_a), 64'd0);
    check("reset tdata", 64'(tdata_a), 64'd0);
    rst = 1'b0;
    step(0, 1);
    check("idle no start", 64'(tvalid_a), 64'd0);

    // basic stream plus saturation on the 16-bit instance
    vecs.delete();
    vecs.push_back(mk(1, 1, 1, 1, 0, 1, 0, 16'h7fff, 1, 1));
    vecs.push_back(mk(0, 1, 1, 2, 0, 1, 0, 16'h8000, 1, 1));
    vecs.push_back(mk(0, 1, 1, 3, 0, 1, 0, 16'h7fff, 0, 1));
    vecs.push_back(mk(0, 1, 1, 4, 1, 1, 0, 16'hfffb, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 0));
    run_table("basic");

    // backpressure on beat 2 for three cycles
    vecs.delete();
    vecs.push_back(mk(1, 1, 1, 1, 0, 1, 0, 16'h7fff, 1, 1));
    vecs.push_back(mk(0, 1, 1, 2, 0, 1, 0, 16'h8000, 1, 1));
    vecs.push_back(mk(0, 0, 1, 2, 0, 1, 0, 16'h8000, 1, 1));
    vecs.push_back(mk(0, 0, 1, 2, 0, 1, 0, 16'h8000, 1, 1));
    vecs.push_back(mk(0, 0, 1, 2, 0, 1, 0, 16'h8000, 1, 1));
    vecs.push_back(mk(0, 1, 1, 3, 0, 1, 0, 16'h7fff, 0, 1));
    vecs.push_back(mk(0, 1, 1, 4, 1, 1, 0, 16'hfffb, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 16'h0000, 0, 0));
    run_table("bp");

    // snapshot isolation: C changes and a second start arrives mid-stream
    set_ca(1, 2, 3, 4);
    step(1, 1);
    check("iso beat1", 64'(tdata_a), 64'd1);
    set_ca(99, 99, 99, 99);
    step(1, 1);
    check("iso beat2", 64'(tdata_a), 64'd2);
    step(0, 1);
    check("iso beat3", 64'(tdata_a), 64'd3);
    step(0, 1);
    check("iso beat4", 64'(tdata_a), 64'd4);
    check("iso tlast", 64'(tlast_a), 64'd1);
    done_cnt = 0;
    vld_cnt  = 0;
    for (int k = 0; k < 4; k++) begin
      step(0, 1);
      done_cnt += int'(done_a);
      vld_cnt  += int'(tvalid_a);
    end
    check("iso done count", 64'(done_cnt), 64'd1);
    check("iso no restream", 64'(vld_cnt), 64'd0);

    // back-to-back: start in the done cycle; second matrix checks full-width pass-through
    set_ca(1, 2, 3, 4);
    step(1, 1);
    step(0, 1);
    step(0, 1);
    step(0, 1);
    check("b2b first last", 64'(tdata_a), 64'd4);
    step(0, 1);
    check("b2b done", 64'(done_a), 64'd1);
    check("b2b bubble", 64'(tvalid_a), 64'd0);
    set_ca(32'sh7fff_ffff, 32'sh8000_0000, 32'sd70000, -32'sd5);
    step(1, 1);
    check("b2b tvalid", 64'(tvalid_a), 64'd1);
    check("b2b busy", 64'(busy_a), 64'd1);
    check("b2b e0", 64'(tdata_a), 64'h7fff_ffff);
    check("b2b e0 tuser", 64'(tuser_a), 64'd0);
    step(0, 1);
    check("b2b e1", 64'(tdata_a), 64'h8000_0000);
    check("b2b e1 tuser", 64'(tuser_a), 64'd0);
    step(0, 1);
    check("b2b e2", 64'(tdata_a), 64'h0001_1170);
    step(0, 1);
    check("b2b e3", 64'(tdata_a), 64'hffff_fffb);
    check("b2b e3 tlast", 64'(tlast_a), 64'd1);
    step(0, 1);
    check("b2b done2", 64'(done_a), 64'd1);

    // reset during beat 3
    set_ca(1, 2, 3, 4);
    step(1, 1);
    step(0, 1);
    step(0, 1);
    check("rst pre beat3", 64'(tdata_a), 64'd3);
    rst = 1'b1;
    step(0, 1);
    rst = 1'b0;
    check("rst tvalid", 64'(tvalid_a), 64'd0);
    check("rst busy", 64'(busy_a), 64'd0);
    check("rst tlast", 64'(tlast_a), 64'd0);
    check("rst done", 64'(done_a), 64'd0);
    done_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      step(0, 1);
      done_cnt += int'(done_a);
    end
    check("rst no done", 64'(done_cnt), 64'd0);
    step(1, 1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst restream e%0d", k), 64'(tdata_a), 64'(k + 1));
      step(0, 1);
    end
    check("rst restream done", 64'(done_a), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
